// File: rtl/axi_lite_intr_pkg.sv
// Shared definitions for the AXI4-Lite interrupt-controller register bank:
// register byte offsets and their word indices, AXI response codes, and the
// write/read handshake state enums. No ports.
package axi_lite_intr_pkg;

  localparam logic [4:0] ADDR_GIE = 5'h00;
  localparam logic [4:0] ADDR_IER = 5'h04;
  localparam logic [4:0] ADDR_ISR = 5'h08;
  localparam logic [4:0] ADDR_IAR = 5'h0C;
  localparam logic [4:0] ADDR_IPR = 5'h10;

  // The bank is decoded on word address bits [4:2].
  localparam logic [2:0] IDX_GIE = ADDR_GIE[4:2];
  localparam logic [2:0] IDX_IER = ADDR_IER[4:2];
  localparam logic [2:0] IDX_ISR = ADDR_ISR[4:2];
  localparam logic [2:0] IDX_IAR = ADDR_IAR[4:2];
  localparam logic [2:0] IDX_IPR = ADDR_IPR[4:2];

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wrState_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rdState_t;

  // Expand a 4-bit byte strobe into a 32-bit bit mask.
  function automatic logic [31:0] strbMask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/axi_lite_intr_slave_status_bit.sv
// intr_status_bit: one interrupt status (ISR) bit.
//   clk, rst : clock, asynchronous active-high reset
//   intrIn   : interrupt source, synchronous to clk
//   ackClr   : acknowledge (IAR write-1) for this bit, valid on the commit edge
//   status   : registered ISR bit
// EDGE_MODE=1 sets on a rising edge of intrIn, EDGE_MODE=0 on every high cycle.
module intr_status_bit #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic intrIn,
  input  logic ackClr,
  output logic status
);

  logic intrD;
  logic setReq;

  assign setReq = EDGE_MODE ? (intrIn & ~intrD) : intrIn;

  // A set arriving on the same edge as an acknowledge wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intrD  <= 1'b0;
      status <= 1'b0;
    end else begin
      intrD  <= intrIn;
      status <= setReq | (status & ~ackClr);
    end
  end

endmodule

// File: rtl/axi_lite_intr_slave.sv
// axi_lite_intr_slave: AXI4-Lite interrupt controller register bank.
//   ACLK, ARESET            : clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*         : write address, data and response channels
//   S_AXI_AR*/R*            : read address and data channels
//   intr_in[C_NUM_OF_INTR]  : interrupt sources, synchronous to ACLK
//   irq                     : registered interrupt request
// Registers: GIE 0x00, IER 0x04, ISR 0x08 (RO), IAR 0x0C (W1C), IPR 0x10 (RO).
module axi_lite_intr_slave
  import axi_lite_intr_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter int          C_NUM_OF_INTR      = 1,
  parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFFFFFF,
  parameter int          C_IRQ_ACTIVE_STATE = 1
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_NUM_OF_INTR-1:0]        intr_in,
  output logic                            irq
);

  localparam logic [31:0] INTR_MASK = (C_NUM_OF_INTR >= 32) ? 32'hFFFFFFFF
                                      : ((32'd1 << C_NUM_OF_INTR) - 32'd1);
  localparam logic IRQ_ACTIVE = (C_IRQ_ACTIVE_STATE != 0);

  wrState_t    wState;
  rdState_t    rState;
  logic [2:0]  wIdx;
  logic [31:0] wData;
  logic [3:0]  wStrb;
  logic [2:0]  rIdx;
  logic        gie;
  logic [31:0] ier;
  logic [31:0] isr;
  logic [31:0] wMask;
  logic [31:0] iarClr;

  function automatic logic [31:0] readReg(input logic [2:0] idx, input logic gieV,
                                          input logic [31:0] ierV, input logic [31:0] isrV);
    case (idx)
      IDX_GIE: return {31'd0, gieV};
      IDX_IER: return ierV;
      IDX_ISR: return isrV;
      IDX_IPR: return isrV & ierV;
      default: return 32'd0;
    endcase
  endfunction

  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;

  assign wMask  = strbMask(wStrb);
  // Acknowledge pulse is only valid on the W_ACK commit edge.
  assign iarClr = (wState == W_ACK && wIdx == IDX_IAR) ? (wData & wMask & INTR_MASK) : 32'd0;

  // Address/data capture: data path, no reset needed.
  always_ff @(posedge ACLK) begin
    if (wState == W_IDLE && S_AXI_AWVALID && S_AXI_WVALID) begin
      wIdx  <= S_AXI_AWADDR[4:2];
      wData <= S_AXI_WDATA;
      wStrb <= S_AXI_WSTRB;
    end
    if (rState == R_IDLE && S_AXI_ARVALID) begin
      rIdx <= S_AXI_ARADDR[4:2];
    end
  end

  // Write channel FSM and writable registers (GIE, IER)
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wState        <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      gie           <= 1'b0;
      ier           <= 32'd0;
    end else begin
      case (wState)
        W_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            wState        <= W_ACK;
          end
        end
        W_ACK: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          S_AXI_BVALID  <= 1'b1;
          wState        <= W_RESP;
          if (wIdx == IDX_GIE && wStrb[0]) gie <= wData[0];
          if (wIdx == IDX_IER) ier <= ((ier & ~wMask) | (wData & wMask)) & INTR_MASK;
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            wState       <= W_IDLE;
          end
        end
        default: wState <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM; RDATA is captured on the ARREADY edge and held
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rState        <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      case (rState)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            S_AXI_ARREADY <= 1'b1;
            rState        <= R_ACK;
          end
        end
        R_ACK: begin
          S_AXI_ARREADY <= 1'b0;
          S_AXI_RVALID  <= 1'b1;
          S_AXI_RDATA   <= readReg(rIdx, gie, ier, isr);
          rState        <= R_DATA;
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            rState       <= R_IDLE;
          end
        end
        default: rState <= R_IDLE;
      endcase
    end
  end

  // Status bits: one detector per implemented source, zero above
  for (genvar i = 0; i < 32; i++) begin : gIsr
    if (i < C_NUM_OF_INTR) begin : gSrc
      intr_status_bit #(.EDGE_MODE(C_INTR_SENSITIVITY[i])) uBit (
        .clk    (ACLK),
        .rst    (ARESET),
        .intrIn (intr_in[i]),
        .ackClr (iarClr[i]),
        .status (isr[i])
      );
    end else begin : gNone
      assign isr[i] = 1'b0;
    end
  end

  // irq output register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) irq <= ~IRQ_ACTIVE;
    else        irq <= (gie & (|(isr & ier))) ? IRQ_ACTIVE : ~IRQ_ACTIVE;
  end

  logic unusedInputs;
  assign unusedInputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, iarClr};

endmodule

// File: tb/tb_axi_lite_intr_slave.sv
// Directed bench for axi_lite_intr_slave with two sources: source 0 edge,
// source 1 level. A register-level model tracks GIE/IER/ISR/irq and a
// forked compare process checks irq and responses on every cycle.
module tb_axi_lite_intr_slave;

  localparam int          NI      = 2;
  localparam logic [31:0] SENS    = 32'hFFFFFFFD;
  localparam logic        IRQ_ACT = 1'b1;
  localparam logic [31:0] MMASK   = (32'd1 << NI) - 32'd1;

  logic        tb_ACLK = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [NI-1:0] intrIn = '0;

  int nCmp = 0;
  int nFail = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_lite_intr_slave #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .C_NUM_OF_INTR(NI),
    .C_INTR_SENSITIVITY(SENS), .C_IRQ_ACTIVE_STATE(1)
  ) dut (
    .ACLK(tb_ACLK), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .intr_in(intrIn), .irq(irq)
  );

  // ---------------- register-level model ----------------
  logic        mGie = 0;
  logic [31:0] mIer = '0, mIsr = '0;
  logic [NI-1:0] mPrev = '0;
  logic        mIrq = 0;
  int          wrReq = 0, mWrDone = 0;
  logic [4:0]  pAddr = '0;
  logic [31:0] pData = '0;
  logic [3:0]  pStrb = '0;

  function automatic logic [31:0] bMask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function logic [31:0] mSetVec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NI; i++) v[i] = SENS[i] ? (intrIn[i] & ~mPrev[i]) : intrIn[i];
    return v;
  endfunction

  function logic [31:0] mClr();
    if (wrReq != mWrDone && pAddr[4:2] == 3'd3) return pData & bMask(pStrb) & MMASK;
    return 32'd0;
  endfunction

  function logic [31:0] mRead(input logic [4:0] a);
    case (a[4:2])
      3'd0: return {31'd0, mGie};
      3'd1: return mIer;
      3'd2: return mIsr;
      3'd4: return mIsr & mIer;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge tb_ACLK or posedge rst) begin
    if (rst) begin
      mGie <= 0; mIer <= '0; mIsr <= '0; mPrev <= '0; mIrq <= 0; mWrDone <= wrReq;
    end else begin
      if (wrReq != mWrDone) begin
        mWrDone <= wrReq;
        if (pAddr[4:2] == 3'd0 && pStrb[0]) mGie <= pData[0];
        if (pAddr[4:2] == 3'd1) mIer <= ((mIer & ~bMask(pStrb)) | (pData & bMask(pStrb))) & MMASK;
      end
      mIsr  <= (mIsr & ~mClr()) | mSetVec();
      mIrq  <= mGie & (|(mIsr & mIer));
      mPrev <= intrIn;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge tb_ACLK);
      if (!rst) begin
        check("irq_model", {31'd0, irq}, {31'd0, mIrq ? IRQ_ACT : ~IRQ_ACT});
        check("bresp_okay", {30'd0, bresp}, 32'd0);
        check("rresp_okay", {30'd0, rresp}, 32'd0);
      end
    end
  endtask

  task automatic abortReset();
    rst = 1'b1;
    #1;
  endtask

  task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int bDelay, input bit riseAtCommit, input bit abortInResp);
    int waitCyc;
    @(negedge tb_ACLK);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1; bready = 0;
    waitCyc = 0;
    do begin @(negedge tb_ACLK); waitCyc++; end while (!(awready && wready) && waitCyc < 20);
    check($sformatf("wr_ready_latency_%02h", addr), waitCyc, 1);
    if (!(awready && wready)) begin awvalid = 0; wvalid = 0; return; end
    pAddr = addr; pData = data; pStrb = strb; wrReq++;
    if (riseAtCommit) intrIn[0] = 1'b1;
    @(negedge tb_ACLK);
    awvalid = 0; wvalid = 0;
    if (riseAtCommit) intrIn[0] = 1'b0;
    check("wr_ready_one_cycle", {30'd0, awready, wready}, 32'd0);
    check("bvalid_rise", {31'd0, bvalid}, 32'd1);
    if (abortInResp) begin
      abortReset();
      check("bvalid_abort", {31'd0, bvalid}, 32'd0);
      repeat (2) @(negedge tb_ACLK);
      rst = 1'b0;
      return;
    end
    repeat (bDelay) begin
      @(negedge tb_ACLK);
      check("bvalid_hold", {31'd0, bvalid}, 32'd1);
    end
    bready = 1;
    @(negedge tb_ACLK);
    check("bvalid_drop", {31'd0, bvalid}, 32'd0);
    bready = 0;
  endtask

  task automatic axiRead(input logic [4:0] addr, input int rDelay, input bit abortInData,
                         output logic [31:0] rd);
    int waitCyc;
    logic [31:0] exp;
    rd = 'x;
    @(negedge tb_ACLK);
    araddr = addr; arvalid = 1; rready = 0;
    waitCyc = 0;
    do begin @(negedge tb_ACLK); waitCyc++; end while (!arready && waitCyc < 20);
    check($sformatf("rd_ready_latency_%02h", addr), waitCyc, 1);
    if (!arready) begin arvalid = 0; return; end
    exp = mRead(addr);
    @(negedge tb_ACLK);
    arvalid = 0;
    check("arready_one_cycle", {31'd0, arready}, 32'd0);
    check("rvalid_rise", {31'd0, rvalid}, 32'd1);
    check($sformatf("rdata_model_%02h", addr), rdata, exp);
    rd = rdata;
    if (abortInData) begin
      abortReset();
      check("rvalid_abort", {31'd0, rvalid}, 32'd0);
      repeat (2) @(negedge tb_ACLK);
      rst = 1'b0;
      return;
    end
    repeat (rDelay) begin
      @(negedge tb_ACLK);
      check("rvalid_hold", {31'd0, rvalid}, 32'd1);
      check("rdata_stable", rdata, rd);
    end
    rready = 1;
    @(negedge tb_ACLK);
    check("rvalid_drop", {31'd0, rvalid}, 32'd0);
    rready = 0;
  endtask

  task automatic pulseSrc0();
    @(negedge tb_ACLK); intrIn[0] = 1'b1;
    @(negedge tb_ACLK); intrIn[0] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    repeat (3) @(negedge tb_ACLK);
    check("reset_outputs", {26'd0, awready, wready, bvalid, arready, rvalid, irq}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    fork compareLoop(); join_none

    for (int a = 0; a < 8; a++) begin
      axiRead(5'(a * 4), 0, 0, rd);
      check($sformatf("reset_read_%02h", a * 4), rd, 32'd0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);

    // IER width masking and BVALID hold under BREADY low
    axiWrite(5'h04, 32'hFFFF_FFFF, 4'hF, 5, 0, 0);
    axiRead(5'h04, 2, 0, rd);
    check("ier_masked", rd, 32'h0000_0003);
    axiWrite(5'h04, 32'h1, 4'hF, 0, 0, 0);
    axiWrite(5'h00, 32'h1, 4'hF, 0, 0, 0);
    axiRead(5'h00, 0, 0, rd);
    check("gie_set", rd, 32'h1);

    // Single-cycle pulse on edge source 0
    @(negedge tb_ACLK); intrIn[0] = 1'b1;
    @(negedge tb_ACLK); intrIn[0] = 1'b0;
    check("irq_edge_n", {31'd0, irq}, 32'd0);
    @(negedge tb_ACLK);
    check("irq_edge_n1", {31'd0, irq}, 32'd1);
    axiRead(5'h08, 0, 0, rd); check("isr_pulse", rd, 32'h1);
    axiRead(5'h10, 0, 0, rd); check("ipr_pulse", rd, 32'h1);
    axiWrite(5'h0C, 32'h1, 4'hF, 0, 0, 0);
    axiRead(5'h10, 0, 0, rd); check("ipr_acked", rd, 32'h0);
    check("irq_acked", {31'd0, irq}, 32'd0);
    axiRead(5'h0C, 0, 0, rd); check("iar_reads_zero", rd, 32'h0);

    // Level source 1 held high: acknowledge cannot clear it
    axiWrite(5'h04, 32'h3, 4'hF, 0, 0, 0);
    @(negedge tb_ACLK); intrIn[1] = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    axiRead(5'h08, 0, 0, rd); check("isr_level", rd, 32'h2);
    axiWrite(5'h0C, 32'h2, 4'hF, 0, 0, 0);
    axiRead(5'h08, 0, 0, rd); check("isr_level_after_ack", rd, 32'h2);
    check("irq_level_stays", {31'd0, irq}, 32'd1);
    // IAR clear on the same edge as a new rising edge: set wins
    pulseSrc0();
    axiRead(5'h08, 0, 0, rd); check("isr_both", rd, 32'h3);
    axiWrite(5'h0C, 32'h1, 4'hF, 0, 1, 0);
    axiRead(5'h08, 0, 0, rd); check("isr_set_wins", rd, 32'h3);
    // IAR with strobe low on byte 0 clears nothing
    @(negedge tb_ACLK); intrIn[1] = 1'b0;
    axiWrite(5'h0C, 32'h3, 4'hE, 0, 0, 0);
    axiRead(5'h08, 0, 0, rd); check("iar_strobe_low", rd, 32'h3);
    axiWrite(5'h0C, 32'h3, 4'hF, 0, 0, 0);
    axiRead(5'h08, 0, 0, rd); check("isr_cleared", rd, 32'h0);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // GIE gating and byte strobes
    axiWrite(5'h00, 32'h0, 4'hF, 0, 0, 0);
    pulseSrc0();
    repeat (3) @(negedge tb_ACLK);
    check("irq_gie_off", {31'd0, irq}, 32'd0);
    axiRead(5'h08, 0, 0, rd); check("isr_gie_off", rd, 32'h1);
    axiWrite(5'h00, 32'h1, 4'h0, 0, 0, 0);
    axiRead(5'h00, 0, 0, rd); check("gie_strobe_low", rd, 32'h0);
    axiWrite(5'h04, 32'h0, 4'hE, 0, 0, 0);
    axiRead(5'h04, 0, 0, rd); check("ier_strobe_low", rd, 32'h3);
    axiWrite(5'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axiRead(5'h00, 0, 0, rd); check("gie_masked", rd, 32'h1);
    check("irq_gie_on", {31'd0, irq}, 32'd1);
    axiWrite(5'h0C, 32'h3, 4'hF, 0, 0, 0);

    // Reset during W_RESP and during R_DATA
    axiWrite(5'h04, 32'h2, 4'hF, 0, 0, 1);
    check("irq_after_abort", {31'd0, irq}, 32'd0);
    axiRead(5'h04, 0, 0, rd); check("ier_after_wabort", rd, 32'h0);
    axiWrite(5'h04, 32'h1, 4'hF, 0, 0, 0);
    axiRead(5'h04, 0, 1, rd);
    axiRead(5'h04, 0, 0, rd); check("ier_after_rabort", rd, 32'h0);
    axiRead(5'h00, 0, 0, rd); check("gie_after_rabort", rd, 32'h0);

    repeat (2) @(negedge tb_ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
